cpu_run_controller: RTL and testbench

//   Sequences the single-cycle CPU on the board. Turns debounced step/run

---
 rtl/cpu_run_controller.sv | 208 ++++++++++++++++++++
 tb/tb_cpu_run_controller.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_controller.sv
// -----------------------------------------------------------------------------
// cpu_run_controller
//   Sequences the single-cycle CPU. Debounced step/run button levels are
//   turned into a one-cycle clock enable (cpu_ce) for the CPU. Three modes:
//   single-step, free-run at a rate of 2^(DIV_BASE+rate_sel) clk cycles per
//   instruction, and an optional PC breakpoint that stops a free run.
//
//   Build option: define CPU_RUN_BP_EN to include the breakpoint compare and
//   the skip_bp flag (BREAK becomes reachable). Without it bp_addr/bp_valid
//   are accepted but ignored and RUN pulses unconditionally.
//
//   State encoding on the state port: 00 HALT, 01 STEP, 10 RUN, 11 BREAK.
// -----------------------------------------------------------------------------
module cpu_run_controller #(
    parameter int ADDR_W   = 32,
    parameter int DIV_W    = 24,   // must be >= DIV_BASE + 8
    parameter int DIV_BASE = 16,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_step,
    input  logic              btn_run,
    input  logic [2:0]        rate_sel,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic              bp_valid,
    output logic              cpu_ce,
    output logic [1:0]        state,
    output logic              halted,
    output logic [CNT_W-1:0]  step_count
);

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_STEP  = 2'b01,
        ST_RUN   = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    // Button vector index: bit 0 = step, bit 1 = run.
    localparam int BTN_STEP = 0;
    localparam int BTN_RUN  = 1;
    localparam int NUM_BTN  = 2;

    state_t             state_reg;
    logic               cpu_ce_reg;
    logic               halted_reg;
    logic [CNT_W-1:0]   step_count_reg;
    logic [DIV_W-1:0]   div_reg;
    logic [2:0]         rate_q_reg;
    logic [NUM_BTN-1:0] btn_q_reg;

    logic [NUM_BTN-1:0] btn_vec;
    logic [NUM_BTN-1:0] btn_rise;
    logic               step_rise;
    logic               run_rise;
    logic               rate_change;
    logic [DIV_W-1:0]   term_count;
    logic               div_at_term;
    logic               run_tick;
    logic               run_fire;
    logic               run_break;
    logic               bp_hit;
    logic               skip_set;

    assign btn_vec = {btn_run, btn_step};

    // Rising-edge detection, one lane per button.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn_edge
            assign btn_rise[gi] = btn_vec[gi] & ~btn_q_reg[gi];
        end
    endgenerate

    assign step_rise = btn_rise[BTN_STEP];
    assign run_rise  = btn_rise[BTN_RUN];

    // A rate change restarts the divider so the new period starts cleanly.
    assign rate_change = (rate_sel != rate_q_reg);

    // Terminal count 2^(DIV_BASE+rate)-1; rate_q_reg equals rate_sel whenever
    // the divider actually advances, so the registered copy keeps the path short.
    assign term_count  = (DIV_W'(1) << (DIV_BASE + int'(rate_q_reg))) - DIV_W'(1);
    assign div_at_term = (div_reg == term_count);

    // Terminal count reached in RUN with no run toggle or rate change pre-empting it.
    assign run_tick  = (state_reg == ST_RUN) && !run_rise && !rate_change && div_at_term;
    assign run_break = run_tick && bp_hit;
    // The cpu_ce_reg term keeps enables from ever landing back to back, even
    // with a degenerate DIV_BASE of 0.
    assign run_fire  = run_tick && !bp_hit && !cpu_ce_reg;

    // Leaving BREAK via the run button arms the one-shot breakpoint bypass.
    assign skip_set = (state_reg == ST_BREAK) && run_rise;

`ifdef CPU_RUN_BP_EN
    logic skip_bp_reg;

    // Breakpoint hit: armed, PC matches, and not the first pulse after resume.
    assign bp_hit = bp_valid && (pc_addr == bp_addr) && !skip_bp_reg;

    // skip_bp: set on resume from BREAK, cleared once a run pulse is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            skip_bp_reg <= 1'b0;
        end else if (skip_set) begin
            skip_bp_reg <= 1'b1;
        end else if (run_fire) begin
            skip_bp_reg <= 1'b0;
        end
    end
`else
    logic unused_bp_inputs;

    // Breakpoint logic is compiled out: inputs are ignored, RUN never stops.
    assign bp_hit           = 1'b0;
    assign unused_bp_inputs = ^{bp_valid, bp_addr, pc_addr, skip_set};
`endif

    // Main sequencer: mode FSM, divider, pulse counter and edge/rate history.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_HALT;
            cpu_ce_reg     <= 1'b0;
            halted_reg     <= 1'b1;
            step_count_reg <= '0;
            div_reg        <= '0;
            // Load the live levels so a button held through reset gives no edge.
            btn_q_reg      <= btn_vec;
            rate_q_reg     <= rate_sel;
        end else begin
            btn_q_reg  <= btn_vec;
            rate_q_reg <= rate_sel;
            cpu_ce_reg <= 1'b0;

            case (state_reg)
                ST_HALT: begin
                    // Run wins when both buttons rise together.
                    if (run_rise) begin
                        state_reg  <= ST_RUN;
                        halted_reg <= 1'b0;
                        div_reg    <= '0;
                    end else if (step_rise) begin
                        state_reg      <= ST_STEP;
                        halted_reg     <= 1'b0;
                        cpu_ce_reg     <= 1'b1;
                        step_count_reg <= step_count_reg + CNT_W'(1);
                    end
                end

                ST_STEP: begin
                    // The enable was issued on entry; one cycle here, then stop.
                    state_reg  <= ST_HALT;
                    halted_reg <= 1'b1;
                end

                ST_RUN: begin
                    if (run_rise) begin
                        // Stop immediately; a pending terminal count is dropped.
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                        div_reg    <= '0;
                    end else if (rate_change) begin
                        div_reg <= '0;
                    end else if (div_at_term) begin
                        div_reg <= '0;
                        if (run_break) begin
                            state_reg  <= ST_BREAK;
                            halted_reg <= 1'b1;
                        end else if (run_fire) begin
                            cpu_ce_reg     <= 1'b1;
                            step_count_reg <= step_count_reg + CNT_W'(1);
                        end
                    end else begin
                        div_reg <= div_reg + DIV_W'(1);
                    end
                end

                ST_BREAK: begin
                    if (run_rise) begin
                        state_reg  <= ST_RUN;
                        halted_reg <= 1'b0;
                        div_reg    <= '0;
                    end else if (step_rise) begin
                        // Executes the instruction sitting at the breakpoint.
                        state_reg      <= ST_STEP;
                        halted_reg     <= 1'b0;
                        cpu_ce_reg     <= 1'b1;
                        step_count_reg <= step_count_reg + CNT_W'(1);
                    end
                end

                default: begin
                    state_reg  <= ST_HALT;
                    halted_reg <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_ce     = cpu_ce_reg;
    assign state      = state_reg;
    assign halted     = halted_reg;
    assign step_count = step_count_reg;

endmodule

// File: tb/tb_cpu_run_controller.sv
// -----------------------------------------------------------------------------
// tb_cpu_run_controller
//   Directed scenarios followed by a randomized soak, all checked against a
//   behavioural model of the run controller. The model tracks the mode, the
//   number of counted cycles since the run timer last restarted, and the
//   pulse count as plain integers. Breakpoint expectations follow
//   CPU_RUN_BP_EN, which should be defined for the whole build.
// -----------------------------------------------------------------------------
module tb_cpu_run_controller;

    localparam int ADDR_W   = 32;
    localparam int DIV_W    = 10;
    localparam int DIV_BASE = 2;
    localparam int CNT_W    = 4;

`ifdef CPU_RUN_BP_EN
    localparam bit BP_EN = 1'b1;
`else
    localparam bit BP_EN = 1'b0;
`endif

    localparam int M_HALT  = 0;
    localparam int M_STEP  = 1;
    localparam int M_RUN   = 2;
    localparam int M_BREAK = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              btn_step;
    logic              btn_run;
    logic [2:0]        rate_sel;
    logic [ADDR_W-1:0] pc_addr;
    logic [ADDR_W-1:0] bp_addr;
    logic              bp_valid;
    logic              cpu_ce;
    logic [1:0]        state;
    logic              halted;
    logic [CNT_W-1:0]  step_count;

    always #5 clk = ~clk;

    cpu_run_controller #(
        .ADDR_W   (ADDR_W),
        .DIV_W    (DIV_W),
        .DIV_BASE (DIV_BASE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_step   (btn_step),
        .btn_run    (btn_run),
        .rate_sel   (rate_sel),
        .pc_addr    (pc_addr),
        .bp_addr    (bp_addr),
        .bp_valid   (bp_valid),
        .cpu_ce     (cpu_ce),
        .state      (state),
        .halted     (halted),
        .step_count (step_count)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit m_valid = 1'b0;
    int m_mode;
    int m_ce;
    int m_count;
    int m_elapsed;
    bit m_skip;
    bit m_prev_step;
    bit m_prev_run;
    int m_prev_rate;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_edge();
        bit sr;
        bit rr;
        bit rc;
        int period;
        int nce;
        if (rst) begin
            m_valid     = 1'b1;
            m_mode      = M_HALT;
            m_ce        = 0;
            m_count     = 0;
            m_elapsed   = 0;
            m_skip      = 1'b0;
            m_prev_step = btn_step;
            m_prev_run  = btn_run;
            m_prev_rate = int'(rate_sel);
            return;
        end
        if (!m_valid) return;
        sr  = btn_step && !m_prev_step;
        rr  = btn_run && !m_prev_run;
        rc  = (int'(rate_sel) != m_prev_rate);
        nce = 0;
        case (m_mode)
            M_HALT: begin
                if (rr) begin
                    m_mode    = M_RUN;
                    m_elapsed = 0;
                end else if (sr) begin
                    m_mode = M_STEP;
                    nce    = 1;
                end
            end
            M_STEP: m_mode = M_HALT;
            M_RUN: begin
                if (rr) begin
                    m_mode = M_HALT;
                end else if (rc) begin
                    m_elapsed = 0;
                end else begin
                    period    = 1 << (DIV_BASE + m_prev_rate);
                    m_elapsed = m_elapsed + 1;
                    if (m_elapsed % period == 0) begin
                        if (BP_EN && bp_valid && (pc_addr == bp_addr) && !m_skip) begin
                            m_mode = M_BREAK;
                        end else begin
                            nce    = 1;
                            m_skip = 1'b0;
                        end
                    end
                end
            end
            default: begin
                if (rr) begin
                    m_mode    = M_RUN;
                    m_skip    = 1'b1;
                    m_elapsed = 0;
                end else if (sr) begin
                    m_mode = M_STEP;
                    nce    = 1;
                end
            end
        endcase
        m_ce        = nce;
        m_count     = (m_count + nce) % (1 << CNT_W);
        m_prev_step = btn_step;
        m_prev_run  = btn_run;
        m_prev_rate = int'(rate_sel);
    endtask

    // One clock: update the model at the edge, compare all outputs 1 ns later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        if (m_valid) begin
            check("cpu_ce", {31'd0, cpu_ce}, m_ce);
            check("state", {30'd0, state}, m_mode);
            check("halted", {31'd0, halted}, ((m_mode == M_HALT) || (m_mode == M_BREAK)) ? 1 : 0);
            check("step_count", {28'd0, step_count}, m_count);
        end
    endtask

    // Clock with a CPU whose PC advances by 4 for each issued enable.
    task automatic tick_cpu();
        tick();
        if (m_ce != 0) pc_addr = pc_addr + 32'd4;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;
        int last;
        int found;
        int got;
        logic [31:0] pc_at;

        rst      = 1'b1;
        btn_step = 1'b1;
        btn_run  = 1'b0;
        rate_sel = 3'd0;
        pc_addr  = 32'h0;
        bp_addr  = 32'hC;
        bp_valid = 1'b0;

        // 1: reset with step held -> no edge; release then press -> one pulse
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("t1_rst_ce", {31'd0, cpu_ce}, 0);
        check("t1_rst_state", {30'd0, state}, 0);
        check("t1_rst_halted", {31'd0, halted}, 1);
        check("t1_rst_count", {28'd0, step_count}, 0);
        repeat (3) tick();
        check("t1_held_no_step", {28'd0, step_count}, 0);
        btn_step = 1'b0;
        repeat (2) tick();
        btn_step = 1'b1;
        pulses = 0;
        repeat (6) begin
            tick();
            pulses += int'(cpu_ce === 1'b1);
        end
        check("t1_one_pulse", pulses, 1);
        btn_step = 1'b0;
        tick();

        // 2: step rise at edge k -> cpu_ce only in k+1, HALT at k+2, count 1
        do_reset();
        btn_step = 1'b1;
        tick();
        check("t2_ce_k1", {31'd0, cpu_ce}, 1);
        check("t2_state_k1", {30'd0, state}, 1);
        tick();
        check("t2_ce_k2", {31'd0, cpu_ce}, 0);
        check("t2_state_k2", {30'd0, state}, 0);
        check("t2_count", {28'd0, step_count}, 1);
        btn_step = 1'b0;
        tick();

        // 3: run at rate 0 (every 4), switch to rate 1 (every 8), then stop
        rate_sel = 3'd0;
        btn_run  = 1'b1;
        tick();
        btn_run = 1'b0;
        pulses  = 0;
        last    = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cpu_ce === 1'b1) begin
                if (last >= 0) check("t3_gap_r0", i - last, 4);
                last = i;
                pulses++;
            end
        end
        check("t3_pulses_r0", pulses, 10);
        rate_sel = 3'd1;
        pulses   = 0;
        last     = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (cpu_ce === 1'b1) begin
                if (last >= 0) check("t3_gap_r1", i - last, 8);
                else check("t3_first_r1", i, 8);
                last = i;
                pulses++;
            end
        end
        check("t3_pulses_r1", pulses, 7);
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        pulses  = 0;
        repeat (30) begin
            tick();
            pulses += int'(cpu_ce === 1'b1);
        end
        check("t3_stopped_pulses", pulses, 0);
        check("t3_stopped_state", {30'd0, state}, 0);

        // 4: breakpoint at 0x0C while PC advances 0,4,8,C
        rate_sel = 3'd0;
        do_reset();
        pc_addr  = 32'h0;
        bp_addr  = 32'hC;
        bp_valid = 1'b1;
        btn_run  = 1'b1;
        tick_cpu();
        btn_run = 1'b0;
        found   = 0;
        for (int i = 0; i < 40; i++) begin
            tick_cpu();
            if (state === 2'b11) begin
                found = 1;
                break;
            end
        end
        check("t4_break_reached", found, BP_EN ? 1 : 0);
        if (BP_EN) begin
            check("t4_break_pc", pc_addr, 32'hC);
            check("t4_break_ce", {31'd0, cpu_ce}, 0);
            check("t4_break_count", {28'd0, step_count}, 3);
            repeat (5) tick_cpu();
            check("t4_break_holds", {30'd0, state}, 3);
            btn_run = 1'b1;
            tick_cpu();
            btn_run = 1'b0;
            check("t4_resume_state", {30'd0, state}, 2);
            got   = 0;
            pc_at = '0;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (cpu_ce === 1'b1) begin
                    got   = 1;
                    pc_at = pc_addr;
                end
                if (m_ce != 0) pc_addr = pc_addr + 32'd4;
                if (got != 0) break;
            end
            check("t4_resume_pulse", got, 1);
            check("t4_resume_pc", pc_at, 32'hC);
            pulses = 0;
            repeat (20) begin
                tick_cpu();
                pulses += int'(cpu_ce === 1'b1);
            end
            check("t4_keeps_running", pulses, 5);
            check("t4_run_state", {30'd0, state}, 2);
        end else begin
            check("t4_no_break_state", {30'd0, state}, 2);
        end
        btn_run = 1'b1;
        tick_cpu();
        btn_run  = 1'b0;
        bp_valid = 1'b0;
        tick();

        // 5: step and run rise together from HALT -> RUN, no step pulse
        do_reset();
        btn_step = 1'b1;
        btn_run  = 1'b1;
        tick();
        check("t5_state", {30'd0, state}, 2);
        check("t5_ce0", {31'd0, cpu_ce}, 0);
        tick();
        check("t5_ce1", {31'd0, cpu_ce}, 0);
        check("t5_count", {28'd0, step_count}, 0);
        btn_step = 1'b0;
        btn_run  = 1'b0;
        tick();
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        check("t5_halt", {30'd0, state}, 0);

        // 6: 16 step presses wrap the counter; reset mid-RUN
        do_reset();
        for (int p = 1; p <= 16; p++) begin
            btn_step = 1'b1;
            tick();
            btn_step = 1'b0;
            tick();
            tick();
            check("t6_count", {28'd0, step_count}, p % 16);
        end
        btn_run = 1'b1;
        tick();
        btn_run = 1'b0;
        repeat (10) tick();
        rst = 1'b1;
        tick();
        check("t6_rst_ce", {31'd0, cpu_ce}, 0);
        check("t6_rst_state", {30'd0, state}, 0);
        check("t6_rst_halted", {31'd0, halted}, 1);
        check("t6_rst_count", {28'd0, step_count}, 0);
        rst = 1'b0;
        tick();

        // Randomized soak against the model
        pc_addr = 32'h0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0)   btn_step = ~btn_step;
            if ($urandom_range(0, 24) == 0)  btn_run  = ~btn_run;
            if ($urandom_range(0, 149) == 0) rate_sel = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 49) == 0)  bp_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) == 0)  bp_addr  = ($urandom_range(0, 1) == 0) ? 32'hC : 32'h14;
            rst = ($urandom_range(0, 499) == 0);
            tick();
            if (m_ce != 0) pc_addr = (pc_addr + 32'd4) & 32'h1F;
        end
        rst = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
